// File: rtl/frame_sync_pkg.sv
// rtl/frame_sync_pkg.sv - shared state type, default parameters and helpers for the frame sync controller
package frame_sync_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } fs_state_e;

    localparam int                     DEF_PAT_W     = 4;
    localparam logic [DEF_PAT_W-1:0]   DEF_SYNC_PAT  = 4'b0110;
    localparam int                     DEF_FRAME_LEN = 16;
    localparam int                     DEF_LOCK_CNT  = 2;
    localparam int                     DEF_MISS_CNT  = 3;

    localparam int IDX_W  = 8;
    localparam int STAT_W = 16;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/frame_sync_matcher.sv
// rtl/frame_sync_matcher.sv - sliding sync-word matcher with fill guard
module sync_matcher
    import frame_sync_pkg::*;
#(
    parameter int               PAT_W    = DEF_PAT_W,
    parameter logic [PAT_W-1:0] SYNC_PAT = DEF_SYNC_PAT
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_en,
    input  logic x,
    output logic match
);

    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  sh_q, sh_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  window;

    // Window is the stored history plus the live bit; fill must cover the history before a match counts.
    always_comb begin
        window = {sh_q, x};
        sh_d   = sh_q;
        fill_d = fill_q;
        if (bit_en) begin
            sh_d = window[PAT_W-2:0];
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
        match = (window == SYNC_PAT) && (fill_q == FILL_MAX);
    end

    // History and fill registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            fill_q <= '0;
        end else begin
            sh_q   <= sh_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/frame_sync_controller.sv
// rtl/frame_sync_controller.sv - frame alignment FSM (hunt/verify/lock); FRAME_SYNC_STATS_EN adds lock_loss_cnt/frame_cnt
module frame_sync_controller
    import frame_sync_pkg::*;
#(
    parameter int               PAT_W     = DEF_PAT_W,
    parameter logic [PAT_W-1:0] SYNC_PAT  = DEF_SYNC_PAT,
    parameter int               FRAME_LEN = DEF_FRAME_LEN,
    parameter int               LOCK_CNT  = DEF_LOCK_CNT,
    parameter int               MISS_CNT  = DEF_MISS_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             x,
    output logic             locked,
    output logic             sof,
    output logic             sync_err,
    output logic             pay_valid,
    output logic             pay_bit,
    output logic [IDX_W-1:0] pay_idx
`ifdef FRAME_SYNC_STATS_EN
    ,
    output logic [STAT_W-1:0] lock_loss_cnt,
    output logic [STAT_W-1:0] frame_cnt
`endif
);

    localparam logic [7:0] CHECK_POS = 8'(FRAME_LEN - 1);
    localparam logic [7:0] PAY_END   = 8'(FRAME_LEN - PAT_W);
    localparam logic [7:0] LOCK_N    = 8'(LOCK_CNT);
    localparam logic [7:0] MISS_N    = 8'(MISS_CNT);

    fs_state_e        state_q, state_d;
    logic [7:0]       pos_q, pos_d;
    logic [7:0]       good_q, good_d;
    logic [7:0]       miss_q, miss_d;
    logic             sof_q, sof_d;
    logic             sync_err_q, sync_err_d;
    logic             pay_valid_q, pay_valid_d;
    logic             pay_bit_q, pay_bit_d;
    logic [IDX_W-1:0] pay_idx_q, pay_idx_d;
    logic             match;
    logic             at_check;

    sync_matcher #(
        .PAT_W    (PAT_W),
        .SYNC_PAT (SYNC_PAT)
    ) u_matcher (
        .clk    (clk),
        .rst    (rst),
        .bit_en (bit_en),
        .x      (x),
        .match  (match)
    );

    // Next state, frame position/counters and the registered output values for this bit.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        good_d      = good_q;
        miss_d      = miss_q;
        sof_d       = 1'b0;
        sync_err_d  = 1'b0;
        pay_valid_d = 1'b0;
        pay_bit_d   = 1'b0;
        pay_idx_d   = '0;
        at_check    = (pos_q == CHECK_POS);
        if (bit_en) begin
            if (state_q != HUNT) begin
                pos_d = at_check ? 8'd0 : pos_q + 8'd1;
            end
            case (state_q)
                HUNT: begin
                    if (match) begin
                        pos_d  = 8'd0;
                        good_d = 8'd1;
                        if (LOCK_CNT == 1) begin
                            state_d = LOCKED;
                            sof_d   = 1'b1;
                            miss_d  = 8'd0;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (at_check) begin
                        if (match) begin
                            good_d = good_q + 8'd1;
                            if ((good_q + 8'd1) >= LOCK_N) begin
                                state_d = LOCKED;
                                sof_d   = 1'b1;
                                miss_d  = 8'd0;
                            end
                        end else begin
                            state_d = HUNT;
                            good_d  = 8'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (pos_q < PAY_END) begin
                        pay_valid_d = 1'b1;
                        pay_bit_d   = x;
                        pay_idx_d   = pos_q;
                    end
                    if (at_check) begin
                        if (match) begin
                            sof_d  = 1'b1;
                            miss_d = 8'd0;
                        end else begin
                            sync_err_d = 1'b1;
                            miss_d     = miss_q + 8'd1;
                            if ((miss_q + 8'd1) >= MISS_N) begin
                                state_d = HUNT;
                                good_d  = 8'd0;
                                miss_d  = 8'd0;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            pos_q       <= '0;
            good_q      <= '0;
            miss_q      <= '0;
            sof_q       <= 1'b0;
            sync_err_q  <= 1'b0;
            pay_valid_q <= 1'b0;
            pay_bit_q   <= 1'b0;
            pay_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            good_q      <= good_d;
            miss_q      <= miss_d;
            sof_q       <= sof_d;
            sync_err_q  <= sync_err_d;
            pay_valid_q <= pay_valid_d;
            pay_bit_q   <= pay_bit_d;
            pay_idx_q   <= pay_idx_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign sof       = sof_q;
    assign sync_err  = sync_err_q;
    assign pay_valid = pay_valid_q;
    assign pay_bit   = pay_bit_q;
    assign pay_idx   = pay_idx_q;

`ifdef FRAME_SYNC_STATS_EN
    logic [STAT_W-1:0] lock_loss_cnt_q, lock_loss_cnt_d;
    logic [STAT_W-1:0] frame_cnt_q, frame_cnt_d;

    // Count lock losses and accepted frames, both saturating.
    always_comb begin
        lock_loss_cnt_d = lock_loss_cnt_q;
        frame_cnt_d     = frame_cnt_q;
        if ((state_q == LOCKED) && (state_d == HUNT)) begin
            lock_loss_cnt_d = sat_inc(lock_loss_cnt_q);
        end
        if (sof_d) begin
            frame_cnt_d = sat_inc(frame_cnt_q);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_loss_cnt_q <= '0;
            frame_cnt_q     <= '0;
        end else begin
            lock_loss_cnt_q <= lock_loss_cnt_d;
            frame_cnt_q     <= frame_cnt_d;
        end
    end

    assign lock_loss_cnt = lock_loss_cnt_q;
    assign frame_cnt     = frame_cnt_q;
`endif

endmodule
